// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clear/load, wrap or one-shot terminal behaviour.
// count, wrap and done are registered; tc is combinational from count and up.
module updown_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MOD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             done_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (count == MaxVal);
    assign at_zero = (count == '0);
    assign tc      = up ? at_max : at_zero;

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        done_d  = done;
        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
            done_d  = 1'b0;
        end else if (en && !done) begin
            // An out-of-range count can only come from a fault; recover to zero.
            if (count > MaxVal) begin
                count_d = '0;
            end else if (tc) begin
                if (one_shot) begin
                    done_d = 1'b1;
                end else begin
                    count_d = up ? '0 : MaxVal;
                    wrap_d  = 1'b1;
                end
            end else if (up) begin
                count_d = count + WIDTH'(1);
            end else begin
                count_d = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: two counters (4-bit mod 16, 5-bit mod 10) driven by shared controls
// and compared against a modulo-arithmetic reference model plus directed expectations.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, clear, load, one_shot;
    logic [3:0] lv_a;
    logic [4:0] lv_b;
    logic [3:0] count_a;
    logic [4:0] count_b;
    logic       tc_a, wrap_a, done_a, tc_b, wrap_b, done_b;

    int checks = 0;
    int errors = 0;

    int mods[2] = '{15, 9};
    int m_cnt[2];
    bit m_done[2];
    bit m_wrap[2];

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(15)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv_a), .one_shot(one_shot), .count(count_a), .tc(tc_a),
        .wrap(wrap_a), .done(done_a)
    );

    updown_mod_counter #(.WIDTH(5), .MOD_MAX(9)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv_b), .one_shot(one_shot), .count(count_b), .tc(tc_b),
        .wrap(wrap_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_done[k] = 0;
            m_wrap[k] = 0;
        end
    endtask

    // Reference behaviour: counting is arithmetic modulo (mod+1); a wrap is a step whose
    // result crosses the ring boundary.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int lv;
            int nxt;
            bit crosses;
            lv = (k == 0) ? int'(lv_a) : int'(lv_b);
            m_wrap[k] = 0;
            if (!reset) begin
                m_cnt[k]  = 0;
                m_done[k] = 0;
            end else if (clear) begin
                m_cnt[k]  = 0;
                m_done[k] = 0;
            end else if (load) begin
                m_cnt[k]  = (lv > mods[k]) ? mods[k] : lv;
                m_done[k] = 0;
            end else if (en && !m_done[k]) begin
                nxt = up ? (m_cnt[k] + 1) % (mods[k] + 1) : (m_cnt[k] + mods[k]) % (mods[k] + 1);
                crosses = up ? (nxt < m_cnt[k]) : (nxt > m_cnt[k]);
                if (crosses && one_shot) begin
                    m_done[k] = 1;
                end else begin
                    m_cnt[k]  = nxt;
                    m_wrap[k] = crosses;
                end
            end
        end
    endtask

    function automatic bit m_tc(int k);
        return up ? (m_cnt[k] == mods[k]) : (m_cnt[k] == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 0; en = 1; up = 1; clear = 0; load = 0; one_shot = 0; lv_a = 4'd9; lv_b = 5'd9;
        model_reset();
        #1;
        checks++;
        if (count_a !== 4'd0 || wrap_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: count=%0d wrap=%b done=%b, want 0/0/0", count_a, wrap_a, done_a);
        end
        checks++;
        if (count_b !== 5'd0 || wrap_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: count=%0d wrap=%b done=%b, want 0/0/0", count_b, wrap_b, done_b);
        end
        load = 1;
        repeat (10) tick();
        checks++;
        if (count_a !== 4'd0 || count_b !== 5'd0) begin
            errors++;
            $display("FAIL reset_ignores_inputs: count_a=%0d count_b=%0d, want 0", count_a, count_b);
        end
        load = 0;
        reset = 1;
    endtask

    task automatic test_count_up();
        en = 1; up = 1; one_shot = 0; clear = 0; load = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (count_a !== 4'((i + 1) % 16) || wrap_a !== ((i + 1) % 16 == 0)
                || tc_a !== ((i + 1) % 16 == 15)) begin
                errors++;
                $display("FAIL count_up_a[%0d]: count=%0d wrap=%b tc=%b, want %0d/%b/%b", i,
                         count_a, wrap_a, tc_a, (i + 1) % 16, (i + 1) % 16 == 0,
                         (i + 1) % 16 == 15);
            end
            checks++;
            if (count_b !== 5'((i + 1) % 10) || wrap_b !== ((i + 1) % 10 == 0)) begin
                errors++;
                $display("FAIL count_up_b[%0d]: count=%0d wrap=%b, want %0d/%b", i, count_b,
                         wrap_b, (i + 1) % 10, (i + 1) % 10 == 0);
            end
        end
    endtask

    task automatic test_count_down();
        clear = 1;
        tick();
        clear = 0;
        checks++;
        if (count_b !== 5'd0 || wrap_b !== 1'b0 || count_a !== 4'd0) begin
            errors++;
            $display("FAIL clear_cycle: count_a=%0d count_b=%0d wrap_b=%b, want 0/0/0", count_a,
                     count_b, wrap_b);
        end
        up = 0;
        #1;
        checks++;
        if (tc_b !== 1'b1) begin
            errors++;
            $display("FAIL tc_down_zero: tc=%b, want 1", tc_b);
        end
        for (int i = 0; i < 11; i++) begin
            int exp;
            tick();
            exp = (10 - (i + 1) % 10) % 10;
            checks++;
            if (count_b !== 5'(exp) || wrap_b !== (exp == 9) || tc_b !== (exp == 0)) begin
                errors++;
                $display("FAIL count_down_b[%0d]: count=%0d wrap=%b tc=%b, want %0d/%b/%b", i,
                         count_b, wrap_b, tc_b, exp, exp == 9, exp == 0);
            end
        end
    endtask

    task automatic test_one_shot();
        int exp_c[4] = '{14, 15, 15, 15};
        bit exp_d[4] = '{0, 0, 1, 1};
        lv_a = 4'd13; lv_b = 5'd13; load = 1; up = 1; en = 1; one_shot = 1;
        tick();
        load = 0;
        checks++;
        if (count_a !== 4'd13 || count_b !== 5'd9) begin
            errors++;
            $display("FAIL one_shot_load: count_a=%0d count_b=%0d, want 13/9", count_a, count_b);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count_a !== 4'(exp_c[i]) || done_a !== exp_d[i] || wrap_a !== 1'b0) begin
                errors++;
                $display("FAIL one_shot_a[%0d]: count=%0d done=%b wrap=%b, want %0d/%b/0", i,
                         count_a, done_a, wrap_a, exp_c[i], exp_d[i]);
            end
        end
        checks++;
        if (count_b !== 5'd9 || done_b !== 1'b1 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_b: count=%0d done=%b wrap=%b, want 9/1/0", count_b, done_b,
                     wrap_b);
        end
        one_shot = 0;
        repeat (2) tick();
        up = 0;
        tick();
        checks++;
        if (count_a !== 4'd15 || done_a !== 1'b1 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky: count=%0d done=%b wrap=%b, want 15/1/0", count_a,
                     done_a, wrap_a);
        end
        clear = 1;
        tick();
        clear = 0;
        checks++;
        if (count_a !== 4'd0 || done_a !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL done_clear: count=%0d done_a=%b done_b=%b, want 0/0/0", count_a,
                     done_a, done_b);
        end
    endtask

    task automatic test_priority();
        lv_a = 4'd7; lv_b = 5'd7; load = 1; clear = 1; en = 1; up = 1;
        tick();
        clear = 0;
        checks++;
        if (count_a !== 4'd0 || count_b !== 5'd0) begin
            errors++;
            $display("FAIL clear_over_load: count_a=%0d count_b=%0d, want 0/0", count_a, count_b);
        end
        lv_a = 4'd4; lv_b = 5'd20;
        tick();
        load = 0;
        checks++;
        if (count_b !== 5'd9 || count_a !== 4'd4 || wrap_b !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: count_b=%0d count_a=%0d wrap_b=%b, want 9/4/0", count_b,
                     count_a, wrap_b);
        end
    endtask

    task automatic test_async_reset();
        lv_a = 4'd6; lv_b = 5'd6; load = 1; en = 0;
        tick();
        load = 0;
        @(negedge clk);
        reset = 0;
        #1;
        model_reset();
        checks++;
        if (count_a !== 4'd0 || count_b !== 5'd0 || done_a !== 1'b0 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count_a=%0d count_b=%0d done=%b wrap=%b, want 0", count_a,
                     count_b, done_a, wrap_a);
        end
        #2;
        reset = 1; en = 1; up = 1;
        tick();
        checks++;
        if (count_a !== 4'd1 || count_b !== 5'd1) begin
            errors++;
            $display("FAIL after_reset: count_a=%0d count_b=%0d, want 1/1", count_a, count_b);
        end
    endtask

    task automatic test_direction_toggle();
        lv_a = 4'd5; lv_b = 5'd5; load = 1; en = 1;
        tick();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            tick();
            checks++;
            if (count_a !== ((i % 2 == 0) ? 4'd6 : 4'd5) || tc_a !== 1'b0 || tc_b !== 1'b0) begin
                errors++;
                $display("FAIL toggle[%0d]: count=%0d tc_a=%b tc_b=%b, want %0d/0/0", i, count_a,
                         tc_a, tc_b, (i % 2 == 0) ? 6 : 5);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom % 4) != 0;
            up       = ($urandom % 2) != 0;
            clear    = ($urandom % 20) == 0;
            load     = ($urandom % 12) == 0;
            one_shot = ($urandom % 3) == 0;
            lv_a     = 4'($urandom);
            lv_b     = 5'($urandom);
            tick();
            checks++;
            if (count_a !== 4'(m_cnt[0]) || wrap_a !== m_wrap[0] || done_a !== m_done[0]
                || tc_a !== m_tc(0)) begin
                errors++;
                $display("FAIL random_a[%0d]: count=%0d wrap=%b done=%b tc=%b, want %0d/%b/%b/%b",
                         i, count_a, wrap_a, done_a, tc_a, m_cnt[0], m_wrap[0], m_done[0],
                         m_tc(0));
            end
            checks++;
            if (count_b !== 5'(m_cnt[1]) || wrap_b !== m_wrap[1] || done_b !== m_done[1]
                || tc_b !== m_tc(1)) begin
                errors++;
                $display("FAIL random_b[%0d]: count=%0d wrap=%b done=%b tc=%b, want %0d/%b/%b/%b",
                         i, count_b, wrap_b, done_b, tc_b, m_cnt[1], m_wrap[1], m_done[1],
                         m_tc(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_one_shot();
        test_priority();
        test_async_reset();
        test_direction_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the count width in bits; legal range 2..32.
REQ-002 Parameter MOD_MAX, default 15, SHALL set the terminal count value; legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL enable counting when 1; count holds when 0.
REQ-006 up  input  1  SHALL select direction: 1 = increment, 0 = decrement.
REQ-007 clear  input  1  SHALL be a synchronous clear to 0.
REQ-008 load  input  1  SHALL be a synchronous load of load_val.
REQ-009 load_val  input  WIDTH  SHALL be the value used by load.
REQ-010 one_shot  input  1  SHALL select mode: 0 = wrap at terminal, 1 = stop at terminal.
REQ-011 count  output  WIDTH  SHALL be the registered count value.
REQ-012 tc  output  1  SHALL be the combinational terminal-count flag.
REQ-013 wrap  output  1  SHALL be a registered one-cycle wrap pulse.
REQ-014 done  output  1  SHALL be a registered sticky one-shot completion flag.

Function
REQ-015 Per-edge priority SHALL be: clear > load > (en and not done) count step > hold.
REQ-016 clear=1 SHALL set count=0 and done=0 on the next edge, regardless of other inputs.
REQ-017 load=1 SHALL set count=load_val on the next edge; load_val > MOD_MAX SHALL be clamped to MOD_MAX; done SHALL clear.
REQ-018 Counting up with count < MOD_MAX SHALL give count+1 on the next edge; latency 1 cycle.
REQ-019 Counting down with count > 0 SHALL give count-1 on the next edge.
REQ-020 Up at count==MOD_MAX, one_shot=0: count SHALL become 0 and wrap SHALL be 1 for exactly the following cycle.
REQ-021 Down at count==0, one_shot=0: count SHALL become MOD_MAX and wrap SHALL be 1 for exactly the following cycle.
REQ-022 At the terminal value with one_shot=1 and en=1: count SHALL hold, done SHALL set to 1, and wrap SHALL stay 0.
REQ-023 done=1 SHALL block counting until clear, load or reset; toggling one_shot SHALL NOT clear done.
REQ-024 tc SHALL be 1 when (up=1 and count==MOD_MAX) or (up=0 and count==0), independent of en.
REQ-025 A direction change SHALL take effect on the same edge it is sampled, with no dead cycle.
REQ-026 wrap SHALL be 0 on every cycle not described in REQ-020/REQ-021, including clear/load cycles.
REQ-027 If count > MOD_MAX is ever observed (must not occur), the next count step SHALL force count to 0.
REQ-028 Arithmetic SHALL be unsigned modulo MOD_MAX+1; no intermediate wider than WIDTH+1 bits.

Reset
REQ-029 reset=0 SHALL immediately, without a clock, force count=0, wrap=0 and done=0.
REQ-030 Reset asserted mid-count SHALL abort the operation; the first enabled edge after reset=1 SHALL give count=1 (up) or MOD_MAX (down).
REQ-031 While reset=0, all inputs SHALL be ignored.

Verification
REQ-032 Defaults, reset=0 for 100 ns, then en=1, up=1, one_shot=0 for 20 edges -> count 0..15,0..3; wrap high for the one cycle after 15->0.
REQ-033 MOD_MAX=9, up=0 starting from 0 -> count 9,8,...,0,9; tc=1 while count==0; wrap pulses after 0->9.
REQ-034 one_shot=1, up=1, load_val=13 loaded -> 13,14,15,15,...; done=1 from the edge after reaching 15; wrap never 1; clear -> count=0, done=0.
REQ-035 load=1, clear=1 and en=1 on the same edge with load_val=7 -> count=0 (clear wins); load_val=20 with MOD_MAX=9 -> count=9.
REQ-036 reset pulsed low for 3 ns between edges at count=6 -> count=0 immediately; first enabled edge after release gives count=1.
REQ-037 up toggled every edge at count=5 with en=1 -> count alternates 6,5,6,5; tc=0 throughout.
